// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state type, block geometry and the
// FIPS 180-4 IV and round constants used by the datapath.
package sha256_pkg;

    localparam int unsigned ROUNDS    = 64;
    localparam int unsigned MSG_WORDS = 16;
    localparam int unsigned IDX_W     = $clog2(ROUNDS);

    typedef enum logic [2:0] {
        StIdle,
        StIv,
        StInit,
        StRound,
        StAcc,
        StDone
    } state_e;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_round_counter.sv
// Round index t for the SHA-256 controller; wraps to 0 after the last round.
module sha256_round_counter #(
    parameter int unsigned ROUNDS    = 64,
    parameter int unsigned MSG_WORDS = 16,
    parameter int unsigned IDX_W     = $clog2(ROUNDS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             enable,
    output logic [IDX_W-1:0] t,
    output logic             t_is_last,
    output logic             t_lt_msg
);

    logic [IDX_W-1:0] t_d, t_q;

    always_comb begin
        t_d = t_q;
        if (clear) begin
            t_d = '0;
        end else if (enable) begin
            t_d = t_is_last ? '0 : t_q + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

    assign t         = t_q;
    assign t_is_last = (t_q == IDX_W'(ROUNDS - 1));
    assign t_lt_msg  = (t_q < IDX_W'(MSG_WORDS));

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block controller: sequences IV load, working-register init, 64 rounds
// with word-serial message intake, hash accumulate and the digest handshake.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS    = 64,
    parameter int unsigned MSG_WORDS = 16,
    parameter int unsigned IDX_W     = $clog2(ROUNDS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             first,
    input  logic             last,
    output logic             start_ready,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic             work_init,
    output logic             work_ld,
    output logic             w_src_msg,
    output logic [IDX_W-1:0] round_idx,
    output logic             hash_iv_ld,
    output logic             hash_acc_ld,
    output logic             blk_done,
    output logic             digest_valid,
    input  logic             digest_ack,
    output logic             busy
);

    state_e           state_d, state_q;
    logic             last_d, last_q;
    logic [IDX_W-1:0] t;
    logic             t_is_last;
    logic             t_lt_msg;
    logic             in_round;

    sha256_round_counter #(
        .ROUNDS    (ROUNDS),
        .MSG_WORDS (MSG_WORDS),
        .IDX_W     (IDX_W)
    ) u_counter (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (work_init),
        .enable    (work_ld),
        .t         (t),
        .t_is_last (t_is_last),
        .t_lt_msg  (t_lt_msg)
    );

    // Outputs decode from registered state so an async reset clears them at once.
    always_comb begin
        in_round     = (state_q == StRound);
        start_ready  = (state_q == StIdle);
        busy         = (state_q != StIdle);
        hash_iv_ld   = (state_q == StIv);
        work_init    = (state_q == StInit);
        msg_ready    = in_round && t_lt_msg;
        w_src_msg    = in_round && t_lt_msg;
        work_ld      = in_round && (!t_lt_msg || msg_valid);
        round_idx    = in_round ? t : '0;
        hash_acc_ld  = (state_q == StAcc);
        blk_done     = (state_q == StAcc) && !last_q;
        digest_valid = (state_q == StDone);
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    last_d  = last;
                    state_d = first ? StIv : StInit;
                end
            end
            StIv:    state_d = StInit;
            StInit:  state_d = StRound;
            StRound: begin
                if (work_ld && t_is_last) begin
                    state_d = StAcc;
                end
            end
            StAcc:   state_d = last_q ? StDone : StIdle;
            StDone: begin
                if (digest_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: block-level reference model,
// per-cycle output compare, directed latency checks and randomized traffic.
module tb_sha256_round_ctrl;

    localparam int ROUNDS = 64;
    localparam int MSG    = 16;

    logic       CLK = 1'b0;
    logic       RST, start, first, last, msg_valid, digest_ack;
    logic       start_ready, msg_ready, work_init, work_ld, w_src_msg;
    logic       hash_iv_ld, hash_acc_ld, blk_done, digest_valid, busy;
    logic [5:0] round_idx;

    sha256_round_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .first        (first),
        .last         (last),
        .start_ready  (start_ready),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .work_init    (work_init),
        .work_ld      (work_ld),
        .w_src_msg    (w_src_msg),
        .round_idx    (round_idx),
        .hash_iv_ld   (hash_iv_ld),
        .hash_acc_ld  (hash_acc_ld),
        .blk_done     (blk_done),
        .digest_valid (digest_valid),
        .digest_ack   (digest_ack),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Block-level model: setup cycles still owed, rounds completed, digest wait.
    bit m_active, m_last, m_wait;
    int m_pre, m_r;

    int o_iv_first, o_iv_n, o_init_last, o_mr_first, o_mr_last;
    int o_ld_n, o_ld_first, o_ld_last, o_acc_first, o_bd_first;
    int o_dv_first, o_sr_first, o_fall_idx, o_hold7;

    task automatic model_reset();
        m_active = 0; m_last = 0; m_wait = 0; m_pre = 0; m_r = 0;
    endtask

    task automatic obs_reset();
        o_iv_first = -1; o_iv_n = 0; o_init_last = -1; o_mr_first = -1; o_mr_last = -1;
        o_ld_n = 0; o_ld_first = -1; o_ld_last = -1; o_acc_first = -1; o_bd_first = -1;
        o_dv_first = -1; o_sr_first = -1; o_fall_idx = -1; o_hold7 = 0;
    endtask

    task automatic cmp(input string nm, input int got, input int want, inout bit bad);
        if (got != want) begin
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, got, want);
            bad = 1;
        end
    endtask

    task automatic expect_eq(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic check();
        int e_sr, e_busy, e_iv, e_wi, e_mr, e_ws, e_ld, e_idx, e_acc, e_bd, e_dv;
        bit bad;
        bad = 0;
        e_iv = 0; e_wi = 0; e_mr = 0; e_ws = 0; e_ld = 0; e_idx = 0;
        e_acc = 0; e_bd = 0; e_dv = 0;
        e_sr   = m_active ? 0 : 1;
        e_busy = m_active ? 1 : 0;
        if (!m_active) begin
        end else if (m_wait) begin
            e_dv = 1;
        end else if (m_pre == 2) begin
            e_iv = 1;
        end else if (m_pre == 1) begin
            e_wi = 1;
        end else if (m_r < ROUNDS) begin
            e_idx = m_r;
            e_mr  = (m_r < MSG) ? 1 : 0;
            e_ws  = e_mr;
            e_ld  = (e_mr == 0 || msg_valid) ? 1 : 0;
        end else begin
            e_acc = 1;
            e_bd  = m_last ? 0 : 1;
        end
        cmp("start_ready", int'(start_ready), e_sr, bad);
        cmp("busy", int'(busy), e_busy, bad);
        cmp("hash_iv_ld", int'(hash_iv_ld), e_iv, bad);
        cmp("work_init", int'(work_init), e_wi, bad);
        cmp("msg_ready", int'(msg_ready), e_mr, bad);
        cmp("w_src_msg", int'(w_src_msg), e_ws, bad);
        cmp("work_ld", int'(work_ld), e_ld, bad);
        cmp("round_idx", int'(round_idx), e_idx, bad);
        cmp("hash_acc_ld", int'(hash_acc_ld), e_acc, bad);
        cmp("blk_done", int'(blk_done), e_bd, bad);
        cmp("digest_valid", int'(digest_valid), e_dv, bad);
        n_tests++;
        if (bad) n_fail++;
    endtask

    task automatic observe();
        if (hash_iv_ld) begin
            o_iv_n++;
            if (o_iv_first < 0) o_iv_first = cyc;
        end
        if (work_init) o_init_last = cyc;
        if (msg_ready) begin
            if (o_mr_first < 0) o_mr_first = cyc;
            o_mr_last = cyc;
        end
        if (work_ld) begin
            o_ld_n++;
            if (o_ld_first < 0) o_ld_first = cyc;
            o_ld_last = cyc;
            if (!w_src_msg && o_fall_idx < 0) o_fall_idx = int'(round_idx);
        end
        if (msg_ready && !work_ld && round_idx == 6'd7) o_hold7++;
        if (hash_acc_ld && o_acc_first < 0) o_acc_first = cyc;
        if (blk_done && o_bd_first < 0) o_bd_first = cyc;
        if (digest_valid && o_dv_first < 0) o_dv_first = cyc;
        if (start_ready && cyc > 0 && o_sr_first < 0) o_sr_first = cyc;
    endtask

    task automatic advance();
        if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_pre    = first ? 2 : 1;
                m_r      = 0;
                m_last   = last;
            end
        end else if (m_wait) begin
            if (digest_ack) begin
                m_active = 0;
                m_wait   = 0;
            end
        end else if (m_pre > 0) begin
            m_pre--;
        end else if (m_r < ROUNDS) begin
            if (m_r >= MSG || msg_valid) m_r++;
        end else begin
            if (m_last) m_wait = 1;
            else m_active = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        check();
        observe();
        @(posedge CLK);
        advance();
        cyc++;
        @(negedge CLK);
    endtask

    task automatic reset_literals(input string tag);
        expect_eq({tag, "_start_ready"}, int'(start_ready), 1);
        expect_eq({tag, "_busy"}, int'(busy), 0);
        expect_eq({tag, "_msg_ready"}, int'(msg_ready), 0);
        expect_eq({tag, "_work_ld"}, int'(work_ld), 0);
        expect_eq({tag, "_work_init"}, int'(work_init), 0);
        expect_eq({tag, "_w_src_msg"}, int'(w_src_msg), 0);
        expect_eq({tag, "_round_idx"}, int'(round_idx), 0);
        expect_eq({tag, "_hash_iv_ld"}, int'(hash_iv_ld), 0);
        expect_eq({tag, "_hash_acc_ld"}, int'(hash_acc_ld), 0);
        expect_eq({tag, "_blk_done"}, int'(blk_done), 0);
        expect_eq({tag, "_digest_valid"}, int'(digest_valid), 0);
    endtask

    // Assert RST between clock edges and check outputs before the next edge.
    task automatic async_reset(input string tag);
        #2;
        RST = 1'b1;
        #1;
        reset_literals(tag);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        bit reached;
        RST = 1'b1; start = 0; first = 0; last = 0; msg_valid = 0; digest_ack = 0;
        model_reset();
        obs_reset();
        #1;
        reset_literals("por");
        @(negedge CLK);
        RST = 1'b0;

        // Single block, no stalls, first=1 last=1.
        obs_reset(); cyc = 0;
        start = 1; first = 1; last = 1; msg_valid = 1;
        tick();
        start = 0;
        while (cyc < 73) begin
            digest_ack = (cyc == 70);
            tick();
        end
        digest_ack = 0;
        expect_eq("blk1_iv_cycle", o_iv_first, 1);
        expect_eq("blk1_init_cycle", o_init_last, 2);
        expect_eq("blk1_ld_count", o_ld_n, 64);
        expect_eq("blk1_ld_first", o_ld_first, 3);
        expect_eq("blk1_ld_last", o_ld_last, 66);
        expect_eq("blk1_mr_first", o_mr_first, 3);
        expect_eq("blk1_mr_last", o_mr_last, 18);
        expect_eq("blk1_acc_cycle", o_acc_first, 67);
        expect_eq("blk1_dv_cycle", o_dv_first, 68);
        expect_eq("blk1_ready_after_ack", o_sr_first, 71);
        expect_eq("blk1_wsrc_fall_idx", o_fall_idx, 16);

        // Five-cycle message stall at t=7.
        begin
            int stall;
            stall = 5;
            obs_reset(); cyc = 0;
            start = 1; first = 1; last = 1; msg_valid = 1;
            tick();
            start = 0;
            while (cyc < 80) begin
                if (m_active && !m_wait && m_pre == 0 && m_r == 7 && stall > 0) begin
                    msg_valid = 0;
                    stall--;
                end else begin
                    msg_valid = 1;
                end
                digest_ack = (cyc == 75);
                tick();
            end
            msg_valid = 1; digest_ack = 0;
            expect_eq("stall_hold_t7", o_hold7, 5);
            expect_eq("stall_acc_cycle", o_acc_first, 72);
            expect_eq("stall_ld_count", o_ld_n, 64);
        end

        // Two-block message.
        obs_reset(); cyc = 0;
        start = 1; first = 1; last = 0; msg_valid = 1;
        tick();
        start = 0;
        while (cyc < 140) begin
            start = (cyc == 68); first = 0; last = 1;
            digest_ack = (cyc == 137);
            tick();
        end
        start = 0; digest_ack = 0;
        expect_eq("two_acc1_cycle", o_acc_first, 67);
        expect_eq("two_blk_done_cycle", o_bd_first, 67);
        expect_eq("two_ready_cycle", o_sr_first, 68);
        expect_eq("two_iv_count", o_iv_n, 1);
        expect_eq("two_init2_cycle", o_init_last, 69);
        expect_eq("two_dv_cycle", o_dv_first, 135);
        expect_eq("two_ld_count", o_ld_n, 128);

        // Async reset at t=40, then a full first=0 block.
        obs_reset(); cyc = 0; reached = 0;
        start = 1; first = 1; last = 1; msg_valid = 1;
        tick();
        start = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (m_active && !m_wait && m_pre == 0 && m_r == 40) reached = 1;
            else tick();
        end
        expect_eq("rst_reach_t40", int'(reached), 1);
        expect_eq("rst_dut_at_t40", int'(round_idx), 40);
        async_reset("midrst");
        obs_reset(); cyc = 0;
        start = 1; first = 0; last = 0; msg_valid = 1;
        tick();
        start = 0;
        while (cyc < 70) tick();
        expect_eq("post_rst_init_cycle", o_init_last, 1);
        expect_eq("post_rst_acc_cycle", o_acc_first, 66);
        expect_eq("post_rst_blk_done", o_bd_first, 66);
        expect_eq("post_rst_ld_count", o_ld_n, 64);

        // Randomized traffic against the model, with one async reset mid-run.
        for (int i = 0; i < 3000; i++) begin
            start      = ($urandom_range(0, 3) == 0);
            first      = $urandom_range(0, 1);
            last       = $urandom_range(0, 1);
            msg_valid  = ($urandom_range(0, 3) != 0);
            digest_ack = ($urandom_range(0, 2) == 0);
            if (i == 1500) begin
                async_reset("rndrst");
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Control FSM for the SHA-256 core. It drives the load enables of the 32-bit working registers A..H, the eight hash registers H0..H7 and the message-schedule window. It processes one 512-bit block per start command, using a word-serial message handshake during rounds 0..15, a round counter, and a digest valid/ack handshake. It has no datapath: it issues only enables, selects and the round index, and the datapath uses round_idx to read the K constant.

Parameters:
ROUNDS, 64, compression rounds per block
MSG_WORDS, 16, message words consumed per block (rounds 0..MSG_WORDS-1)
IDX_W, 6, round_idx width, equal to $clog2(ROUNDS)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, asynchronous, active-high
start  in  1  begin one block; sampled only in IDLE
first  in  1  qualifies start; 1 loads IV into H0..H7 before the block
last  in  1  qualifies start; 1 means present the digest after this block
start_ready  out  1  high in IDLE only
msg_valid  in  1  message word on datapath input is valid
msg_ready  out  1  controller consumes the word this cycle
work_init  out  1  load A..H from H0..H7
work_ld  out  1  round update of A..H; also shifts the W window
w_src_msg  out  1  1: W_t = message word; 0: W_t = schedule sigma sum
round_idx  out  IDX_W  current round t
hash_iv_ld  out  1  load IV constants into H0..H7
hash_acc_ld  out  1  H_i <= H_i + working register (mod 2^32)
blk_done  out  1  one-cycle pulse when a non-last block completes
digest_valid  out  1  H0..H7 hold the final digest
digest_ack  in  1  consumer has taken the digest
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, IV, INIT, ROUND, ACC, DONE. All outputs decode combinationally from the registered state, the counter t and msg_valid.
- Reset (asynchronous, any time, including mid-block): state=IDLE, t=0, last flag=0. Every output except start_ready reads 0, and start_ready=1. No partial block resumes after reset.
- IDLE: start=1 latches last. If first=1 go to IV, else go to INIT. start is ignored in every other state.
- IV: hash_iv_ld=1 for 1 cycle, then INIT.
- INIT: work_init=1 for 1 cycle, t<=0, then ROUND.
- ROUND with t<MSG_WORDS: msg_ready=1 and w_src_msg=1.
  - If msg_valid=1: work_ld=1 and t<=t+1.
  - If msg_valid=0: stall. work_ld=0 and t holds, with no limit on stall length.
- ROUND with t>=MSG_WORDS: msg_ready=0, w_src_msg=0, work_ld=1 unconditionally, t<=t+1.
- After the work_ld cycle with t=ROUNDS-1, go to ACC. t wraps to 0 and never exceeds ROUNDS-1.
- ACC: hash_acc_ld=1 for 1 cycle.
  - If last=0: blk_done=1 in this same cycle, then IDLE.
  - If last=1: go to DONE.
- DONE: digest_valid=1, held until a cycle with digest_ack=1, then IDLE in the next cycle. digest_ack outside DONE is ignored.
- round_idx=t in ROUND. It reads 0 in all other states.
- Latency with no stalls, first=1 (start accepted at cycle 0): IV=1, INIT=2, ROUND=3..66, ACC=67, DONE from 68.
- Latency with no stalls, first=0: INIT=1, ROUND=2..65, ACC=66.
- Each message stall adds 1 cycle.
- Throughput: start_ready returns the cycle after ACC (non-last block) or after the ack (last block).
- msg_ready is never high outside ROUND, so words offered early or late are not consumed.
- Simultaneous start with first=1 and last=1 is a valid single-block message.

Decomposition:
- Package sha256_pkg: state enum type, ROUNDS, MSG_WORDS, IV constant array H0..H7, K[0:63] constant array. The datapath shares the same package.
- One optional sub-module, sha256_round_counter: holds t, with inputs clear/enable and outputs t, t_is_last and t_lt_msg.
- Everything else stays flat in the FSM.

Test Plan:
- Single block, msg_valid always 1, start with first=1, last=1 at cycle 0:
  - hash_iv_ld at 1, work_init at 2.
  - 64 work_ld cycles 3..66; msg_ready high only on 3..18.
  - hash_acc_ld at 67; digest_valid from 68.
  - ack at 70, then start_ready=1 at 71.
- Stalls: drop msg_valid for 5 cycles at t=7.
  - round_idx holds 7 and work_ld=0 for all 5 cycles.
  - ACC is reached 5 cycles later, at 72.
- Two-block message, both blocks with no stalls:
  - Block 1, first=1, last=0 at cycle 0: ACC at 67 with blk_done=1 and digest_valid=0; start_ready at 68.
  - Block 2, first=0, last=1 at cycle 68: no hash_iv_ld, work_init at 69, DONE at 135.
- Async reset: assert RST at t=40 of ROUND.
  - All outputs 0 and start_ready=1 immediately, without waiting for a clock edge.
  - After release, a new block runs with the full no-stall cycle count.
- Ignore rules:
  - start asserted in ROUND and DONE has no effect.
  - digest_ack in IDLE has no effect.
  - msg_valid in INIT, ACC and IDLE is not consumed (msg_ready=0).
- Round index boundary: round_idx sweeps 0..63 exactly once per block, and w_src_msg falls on the cycle where round_idx=16.
